// File: rtl/mnist_test_pkg.sv
// Shared types and width helpers for the MNIST image-stream checker.
package mnist_test_pkg;

  typedef enum logic [2:0] {
    IDLE,
    STREAM,
    WAIT,
    CHECK,
    DONE
  } state_e;

  localparam int DEFAULT_NUM_CLASSES = 10;
  localparam int LABEL_W             = 4;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int addr_w(input int images, input int bytes_per_image);
    return cnt_w(images * bytes_per_image);
  endfunction

  function automatic int idx_w(input int images);
    return $clog2(images + 1);
  endfunction

endpackage

// File: rtl/mnist_stream_checker_if.sv
// Image-ROM and DUT-side bus of the stream checker; master is the checker.
interface mnist_stream_checker_if #(
  parameter int ADDR_W = 14
);

  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data;
  logic [7:0]        dut_data;
  logic              dut_valid;
  logic [3:0]        dut_index;
  logic [7:0]        dut_value;

  modport master (
    output rom_addr,
    output dut_data,
    output dut_valid,
    input  rom_data,
    input  dut_index,
    input  dut_value
  );

  modport slave (
    input  rom_addr,
    input  dut_data,
    input  dut_valid,
    output rom_data,
    output dut_index,
    output dut_value
  );

endinterface

// File: rtl/mnist_stream_checker_mod_counter.sv
// Wrapping counter 0..MODULUS-1 using a terminal-count compare instead of a divider.
module mod_counter #(
  parameter int MODULUS = 10,
  parameter int W       = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] LAST = W'(MODULUS - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/mnist_stream_checker.sv
// Streams packed test images from ROM into the LGN MNIST core and checks each predicted class.
// Optional macro STREAM_CHECKER_FIRST_FAIL_EN adds first-mismatch capture registers.
module mnist_stream_checker
  import mnist_test_pkg::*;
#(
  parameter int IMAGE_COUNT     = 480,
  parameter int BYTES_PER_IMAGE = 32,
  parameter int RESULT_LATENCY  = 2,
  parameter int NUM_CLASSES     = DEFAULT_NUM_CLASSES,
  parameter int STOP_ON_FAIL    = 1,
  localparam int ADDR_W         = addr_w(IMAGE_COUNT, BYTES_PER_IMAGE),
  localparam int IDX_W          = idx_w(IMAGE_COUNT)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  mnist_stream_checker_if.master bus,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic                   fail,
  output logic [IDX_W-1:0]       image_idx,
  output logic [LABEL_W-1:0]     expected_label,
  output logic [LABEL_W-1:0]     captured_index,
  output logic [7:0]             captured_value,
  output logic [IDX_W-1:0]       error_count,
  output logic [IDX_W-1:0]       first_fail_idx,
  output logic [LABEL_W-1:0]     first_fail_got
);

  localparam int BYTE_W   = cnt_w(BYTES_PER_IMAGE);
  localparam int WAIT_CYC = RESULT_LATENCY + 2;
  localparam int WAIT_W   = cnt_w(WAIT_CYC);

  localparam logic [ADDR_W-1:0] ADDR_MAX  = ADDR_W'(IMAGE_COUNT * BYTES_PER_IMAGE - 1);
  localparam logic [IDX_W-1:0]  LAST_IMG  = IDX_W'(IMAGE_COUNT - 1);
  localparam logic [IDX_W-1:0]  ERR_MAX   = '1;
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(BYTES_PER_IMAGE - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_CYC - 1);

  state_e              state;
  logic                start_run;
  logic                issue_vld_p0;
  logic                vld_p1;
  logic [BYTE_W-1:0]   byte_cnt;
  logic                byte_last;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                mismatch;
  logic                last_img;
  logic                stop_now;
  logic                label_inc;

  assign start_run    = start && ((state == IDLE) || (state == DONE));
  assign issue_vld_p0 = (state == STREAM);
  assign byte_last    = (byte_cnt == BYTE_LAST);
  assign mismatch     = (captured_index != expected_label);
  assign last_img     = (image_idx == LAST_IMG);
  assign stop_now     = last_img || (mismatch && (STOP_ON_FAIL != 0));
  assign label_inc    = (state == CHECK) && !stop_now;

  mod_counter #(
    .MODULUS (BYTES_PER_IMAGE),
    .W       (BYTE_W)
  ) u_byte_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_run),
    .inc   (issue_vld_p0),
    .count (byte_cnt)
  );

  mod_counter #(
    .MODULUS (NUM_CLASSES),
    .W       (LABEL_W)
  ) u_label_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_run),
    .inc   (label_inc),
    .count (expected_label)
  );

  // p0 address issue -> p1 synchronous ROM read -> p2 registered byte on dut_data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1        <= 1'b0;
      bus.dut_valid <= 1'b0;
      bus.dut_data  <= '0;
    end else begin
      vld_p1        <= issue_vld_p0;
      bus.dut_valid <= vld_p1;
      bus.dut_data  <= bus.rom_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      bus.rom_addr   <= '0;
      wait_cnt       <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      fail           <= 1'b0;
      image_idx      <= '0;
      error_count    <= '0;
      captured_index <= '0;
      captured_value <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_run) begin
            state        <= STREAM;
            bus.rom_addr <= '0;
            busy         <= 1'b1;
            done         <= 1'b0;
            pass         <= 1'b0;
            fail         <= 1'b0;
            image_idx    <= '0;
            error_count  <= '0;
          end
        end
        STREAM: begin
          // Running address across images; holds at the top of the ROM.
          if (bus.rom_addr != ADDR_MAX) begin
            bus.rom_addr <= bus.rom_addr + 1'b1;
          end
          if (byte_last) begin
            state    <= WAIT;
            wait_cnt <= '0;
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          // Two pipeline cycles plus RESULT_LATENCY after the last address issue.
          if (wait_cnt == WAIT_LAST) begin
            state          <= CHECK;
            captured_index <= bus.dut_index;
            captured_value <= bus.dut_value;
          end
        end
        CHECK: begin
          if (mismatch) begin
            fail <= 1'b1;
            if (error_count != ERR_MAX) begin
              error_count <= error_count + 1'b1;
            end
          end
          if (stop_now) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= !(fail || mismatch);
          end else begin
            state     <= STREAM;
            image_idx <= image_idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef STREAM_CHECKER_FIRST_FAIL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_fail_idx <= '0;
      first_fail_got <= '0;
    end else if (start_run) begin
      first_fail_idx <= '0;
      first_fail_got <= '0;
    end else if ((state == CHECK) && mismatch && !fail) begin
      first_fail_idx <= image_idx;
      first_fail_got <= captured_index;
    end
  end
`else
  assign first_fail_idx = '0;
  assign first_fail_got = '0;
`endif

endmodule

// File: tb/tb_mnist_stream_checker.sv
// Bench for mnist_stream_checker: two instances (stop-on-fail / continue, latency 2 / 4) with ROM and DUT models.
module tb_mnist_stream_checker;

  localparam int N  = 12;
  localparam int B  = 4;
  localparam int NB = N * B;
  localparam int AW = 6;

  typedef logic [7:0] fb_t [N];

  typedef struct {
    int err;
    int last_idx;
    int images;
    int pass;
    int cidx;
    int cval;
    int ffi;
    int ffg;
  } res_t;

  typedef struct {
    int sel;
    int bad0;
    int val0;
    int bad1;
    int val1;
    int sh;
    int exp_pass;
    int exp_err;
    int exp_idx;
    int exp_cidx;
    int exp_ffi;
    int exp_ffg;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_n;
  logic [1:0]          start_s;
  logic [1:0]          busy_s, done_s, pass_s, fail_s;
  logic [1:0][3:0]     idx_s, lab_s, cidx_s, err_s, ffi_s, ffg_s;
  logic [1:0][7:0]     cval_s;
  logic [1:0][7:0]     pos_w, bad_w;
  logic [7:0]          mem [2][NB];
  int                  shift [2];
  int                  checks = 0;
  int                  errors = 0;

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int LAT  = (g == 0) ? 2 : 4;
    localparam int STOP = (g == 0) ? 1 : 0;

    mnist_stream_checker_if #(.ADDR_W(AW)) bus ();

    int         since   = 100;
    int         pos     = 0;
    int         bad     = 0;
    logic [7:0] first_b = 8'd0;
    logic       prev_v  = 1'b0;

    assign pos_w[g] = 8'(pos);
    assign bad_w[g] = 8'(bad);

    mnist_stream_checker #(
      .IMAGE_COUNT     (N),
      .BYTES_PER_IMAGE (B),
      .RESULT_LATENCY  (LAT),
      .NUM_CLASSES     (10),
      .STOP_ON_FAIL    (STOP)
    ) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start_s[g]),
      .bus            (bus),
      .busy           (busy_s[g]),
      .done           (done_s[g]),
      .pass           (pass_s[g]),
      .fail           (fail_s[g]),
      .image_idx      (idx_s[g]),
      .expected_label (lab_s[g]),
      .captured_index (cidx_s[g]),
      .captured_value (cval_s[g]),
      .error_count    (err_s[g]),
      .first_fail_idx (ffi_s[g]),
      .first_fail_got (ffg_s[g])
    );

    // Synchronous-read image ROM
    always @(posedge clk) bus.rom_data <= mem[g][bus.rom_addr];

    // DUT stand-in: answers (first byte mod 10) only LAT(+shift) cycles after the last valid byte
    always @(negedge clk) begin
      if (start_s[g] && !busy_s[g]) begin
        pos = 0;
        bad = 0;
      end
      if (bus.dut_valid) begin
        if (!prev_v) first_b = bus.dut_data;
        if (pos >= NB || bus.dut_data !== mem[g][pos]) bad++;
        pos++;
        since = 0;
      end else if (since < 1000) begin
        since++;
      end
      prev_v = bus.dut_valid;
      if (since == LAT + shift[g]) begin
        bus.dut_index = 4'(first_b % 10);
        bus.dut_value = first_b;
      end else begin
        bus.dut_index = 4'(first_b % 10 + 1);
        bus.dut_value = 8'hEE;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: walk the images with the labelling rule, stopping early when requested.
  function automatic res_t ref_run(input fb_t fbv, input bit stop, input int sh);
    res_t r;
    int   got;
    r = '{default: 0};
    for (int i = 0; i < N; i++) begin
      got        = int'(fbv[i]) % 10 + ((sh != 0) ? 1 : 0);
      r.images   = i + 1;
      r.last_idx = i;
      r.cidx     = got;
      r.cval     = (sh != 0) ? 'hEE : int'(fbv[i]);
      if (got != i % 10) begin
        if (r.err == 0) begin
          r.ffi = i;
          r.ffg = got;
        end
        r.err++;
        if (stop) break;
      end
    end
    r.pass = (r.err == 0) ? 1 : 0;
    return r;
  endfunction

  task automatic load_rom(input int sel, input fb_t fbv);
    for (int i = 0; i < N; i++)
      for (int b = 0; b < B; b++)
        mem[sel][i*B + b] = (b == 0) ? fbv[i] : 8'($urandom);
  endtask

  task automatic run_check(input int sel, input fb_t fbv, input int sh, input res_t e,
                           input string tag, input int poke);
    int cyc;
    int p;
    int ffi_e;
    int ffg_e;
    logic [15:0] snap;
    p = B + 2 + ((sel == 0) ? 2 : 4) + 1;
`ifdef STREAM_CHECKER_FIRST_FAIL_EN
    ffi_e = e.ffi;
    ffg_e = e.ffg;
`else
    ffi_e = 0;
    ffg_e = 0;
`endif
    load_rom(sel, fbv);
    shift[sel] = sh;
    @(posedge clk); #1 start_s[sel] = 1'b1;
    @(posedge clk); #1 start_s[sel] = 1'b0;
    @(negedge clk);
    cyc = 1;
    chk({tag, " busy_after_start"}, busy_s[sel], 1);
    while (!done_s[sel] && cyc < 400) begin
      if (cyc == poke) begin
        start_s[sel] = 1'b1;
        @(negedge clk);
        cyc++;
        start_s[sel] = 1'b0;
        chk({tag, " idx_after_busy_start"}, idx_s[sel], 1);
        chk({tag, " busy_after_busy_start"}, busy_s[sel], 1);
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    chk({tag, " cycles"}, cyc, e.images * p + 1);
    chk({tag, " done"}, done_s[sel], 1);
    chk({tag, " busy"}, busy_s[sel], 0);
    chk({tag, " pass"}, pass_s[sel], e.pass);
    chk({tag, " fail"}, fail_s[sel], (e.pass == 0) ? 1 : 0);
    chk({tag, " error_count"}, err_s[sel], e.err);
    chk({tag, " image_idx"}, idx_s[sel], e.last_idx);
    chk({tag, " expected_label"}, lab_s[sel], e.last_idx % 10);
    chk({tag, " captured_index"}, cidx_s[sel], e.cidx);
    chk({tag, " captured_value"}, cval_s[sel], e.cval);
    chk({tag, " first_fail_idx"}, ffi_s[sel], ffi_e);
    chk({tag, " first_fail_got"}, ffg_s[sel], ffg_e);
    chk({tag, " bytes_streamed"}, pos_w[sel], e.images * B);
    chk({tag, " byte_errors"}, bad_w[sel], 0);
    snap = {done_s[sel], pass_s[sel], fail_s[sel], 1'b0, idx_s[sel], err_s[sel], cidx_s[sel]};
    repeat (3) @(negedge clk);
    chk({tag, " status_hold"},
        {done_s[sel], pass_s[sel], fail_s[sel], 1'b0, idx_s[sel], err_s[sel], cidx_s[sel]}, snap);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [6];
    fb_t  fbv;
    res_t e;
    int   cyc;

    rst_n   = 1'b0;
    start_s = 2'b00;
    shift   = '{0, 0};
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < NB; a++) mem[s][a] = 8'd0;

    //          sel bad0 v0 bad1 v1 sh pass err idx cidx ffi ffg
    vt[0] = '{0, -1, 0, -1, 0, 0, 1, 0,  11, 1, 0, 0};
    vt[1] = '{0,  5, 7, -1, 0, 0, 0, 1,  5,  7, 5, 7};
    vt[2] = '{1,  3, 5,  8, 2, 0, 0, 2,  11, 1, 3, 5};
    vt[3] = '{1, -1, 0, -1, 0, 0, 1, 0,  11, 1, 0, 0};
    vt[4] = '{1, -1, 0, -1, 0, 1, 0, 12, 11, 2, 0, 1};
    vt[5] = '{0, -1, 0, -1, 0, 1, 0, 1,  0,  1, 0, 1};

    repeat (3) @(negedge clk);
    chk("reset flags", {busy_s, done_s, pass_s, fail_s}, 0);
    chk("reset counts", {idx_s, err_s, cidx_s, lab_s}, 0);
    chk("reset capture", {cval_s, ffi_s, ffg_s}, 0);
    chk("reset bus", {g_inst[0].bus.rom_addr, g_inst[0].bus.dut_valid, g_inst[0].bus.dut_data,
                      g_inst[1].bus.rom_addr, g_inst[1].bus.dut_valid, g_inst[1].bus.dut_data}, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < N; i++) fbv[i] = 8'(i);
      if (vt[k].bad0 >= 0) fbv[vt[k].bad0] = 8'(vt[k].val0);
      if (vt[k].bad1 >= 0) fbv[vt[k].bad1] = 8'(vt[k].val1);
      e.err      = vt[k].exp_err;
      e.last_idx = vt[k].exp_idx;
      e.images   = vt[k].exp_idx + 1;
      e.pass     = vt[k].exp_pass;
      e.cidx     = vt[k].exp_cidx;
      e.cval     = (vt[k].sh != 0) ? 'hEE : int'(fbv[vt[k].exp_idx]);
      e.ffi      = vt[k].exp_ffi;
      e.ffg      = vt[k].exp_ffg;
      run_check(vt[k].sel, fbv, vt[k].sh, e, $sformatf("row%0d", k), -1);
    end

    for (int r = 0; r < 6; r++) begin
      int sel;
      sel = int'($urandom_range(0, 1));
      for (int i = 0; i < N; i++)
        fbv[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'(i + 10 * int'($urandom_range(0, 20)));
      e = ref_run(fbv, sel == 0, 0);
      run_check(sel, fbv, 0, e, $sformatf("rand%0d", r), -1);
    end

    // Reset in the middle of image 2 streaming, then a clean rerun
    for (int i = 0; i < N; i++) fbv[i] = 8'(i);
    load_rom(0, fbv);
    shift[0] = 0;
    @(posedge clk); #1 start_s[0] = 1'b1;
    @(posedge clk); #1 start_s[0] = 1'b0;
    cyc = 0;
    while (idx_s[0] != 4'd2 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    chk("midrun image", idx_s[0], 2);
    chk("midrun busy", busy_s[0], 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrun reset flags", {busy_s, done_s, pass_s, fail_s}, 0);
    chk("midrun reset counts", {idx_s, err_s, cidx_s, lab_s, cval_s}, 0);
    chk("midrun reset bus", {g_inst[0].bus.rom_addr, g_inst[0].bus.dut_valid, g_inst[0].bus.dut_data}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    e = ref_run(fbv, 1'b1, 0);
    run_check(0, fbv, 0, e, "after_reset", -1);

    // Start pulse while instance 1 is in WAIT of image 1
    e = ref_run(fbv, 1'b0, 0);
    run_check(1, fbv, 0, e, "start_busy", 17);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
